// File: rtl/d_ff_pkg.sv
// Shared constants and helpers for the d_ff_sync register family.
package d_ff_pkg;

    localparam int D_FF_DEFAULT_WIDTH  = 1;
    localparam int D_FF_DEFAULT_STAGES = 1;
    localparam int D_FF_MAX_WIDTH      = 1024;
    localparam int D_FF_MAX_STAGES     = 64;

    // Returned at the maximum width; callers cast it down to their own WIDTH.
    function automatic logic [D_FF_MAX_WIDTH-1:0] d_ff_zeros(input int width);
        logic [D_FF_MAX_WIDTH-1:0] result;
        result = '0;
        for (int i = 0; i < D_FF_MAX_WIDTH; i++) begin
            if (i < width) begin
                result[i] = 1'b0;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// One WIDTH-bit register with synchronous active-high reset.
module d_ff_stage
    import d_ff_pkg::*;
#(
    parameter int              WIDTH       = D_FF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(d_ff_zeros(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/d_ff_sync.sv
// Parameterised D register / delay line: STAGES cascaded WIDTH-bit stages,
// all reset synchronously to RESET_VALUE.
module d_ff_sync
    import d_ff_pkg::*;
#(
    parameter int               WIDTH       = D_FF_DEFAULT_WIDTH,
    parameter int               STAGES      = D_FF_DEFAULT_STAGES,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(d_ff_zeros(WIDTH))
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (WIDTH < 1 || WIDTH > D_FF_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "d_ff_sync: WIDTH=%0d outside 1..%0d", WIDTH, D_FF_MAX_WIDTH);
    end
    if (STAGES < 1 || STAGES > D_FF_MAX_STAGES) begin : g_bad_stages
        $fatal(1, "d_ff_sync: STAGES=%0d outside 1..%0d", STAGES, D_FF_MAX_STAGES);
    end

    logic [WIDTH-1:0] stage_q [STAGES];

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic [WIDTH-1:0] stage_d;
        if (i == 0) begin : g_first
            assign stage_d = d;
        end else begin : g_chain
            assign stage_d = stage_q[i-1];
        end

        d_ff_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .d   (stage_d),
            .q   (stage_q[i])
        );
    end

    assign q = stage_q[STAGES-1];

`ifndef SYNTHESIS
    // Behavioural shadow of the input history used only by the checks below.
    logic [WIDTH-1:0] hist [STAGES];
    int               low_cnt;
    logic             rst_q;

    always_ff @(posedge clk) begin
        if (rst_q) begin
            assert (q === RESET_VALUE)
                else $error("d_ff_sync: q=%h not RESET_VALUE after reset", q);
        end
        if (low_cnt >= STAGES) begin
            assert (q === hist[STAGES-1])
                else $error("d_ff_sync: q=%h expected delayed d=%h", q, hist[STAGES-1]);
        end

        rst_q   <= rst;
        hist[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
            hist[i] <= hist[i-1];
        end
        if (rst) begin
            low_cnt <= 0;
        end else if (low_cnt < STAGES) begin
            low_cnt <= low_cnt + 1;
        end
    end
`endif

endmodule

// File: tb/tb_d_ff_sync.sv
// Directed and randomized checks of d_ff_sync at default and 8x3 configurations.
module tb_d_ff_sync;

    localparam int         N_RAND = 1000;
    localparam logic [7:0] RV1    = 8'hA5;

    logic       clk;
    logic       rst0, rst1;
    logic [0:0] d0, q0;
    logic [7:0] d1, q1;

    int errors = 0;
    int checks = 0;

    logic [7:0] dh [N_RAND];
    logic       rh [N_RAND];

    d_ff_sync dut0 (
        .clk (clk),
        .rst (rst0),
        .d   (d0),
        .q   (q0)
    );

    d_ff_sync #(
        .WIDTH       (8),
        .STAGES      (3),
        .RESET_VALUE (RV1)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .d   (d1),
        .q   (q1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected q after edge k: reset value if any edge in the last s edges
    // carried rst, otherwise the d captured s-1 edges before edge k.
    function automatic logic [7:0] model(input int k, input int s, input logic [7:0] rv);
        for (int j = k - s + 1; j <= k; j++) begin
            if (j < 0 || rh[j]) return rv;
        end
        return dh[k-s+1];
    endfunction

    initial begin
        logic [7:0] e;

        rst0 = 1'b1; d0 = 1'b1;
        rst1 = 1'b1; d1 = 8'hFF;

        tick();
        check("reset_dominates", {7'd0, q0}, 8'h00);
        check("w8_reset", q1, RV1);

        rst0 = 1'b0; d0 = 1'b0;
        tick();
        check("capture0", {7'd0, q0}, 8'h00);
        d0 = 1'b1;
        tick();
        check("capture1", {7'd0, q0}, 8'h01);
        tick();
        check("hold1", {7'd0, q0}, 8'h01);

        rst0 = 1'b1;
        tick();
        check("midstream_reset", {7'd0, q0}, 8'h00);
        rst0 = 1'b0;
        tick();
        check("after_reset", {7'd0, q0}, 8'h01);

        #1 d0 = 1'b0;
        #1 check("glitch_low", {7'd0, q0}, 8'h01);
        #1 d0 = 1'b1;
        #1 check("glitch_high", {7'd0, q0}, 8'h01);
        tick();
        check("glitch_edge", {7'd0, q0}, 8'h01);

        rst1 = 1'b0; d1 = 8'h01;
        tick();
        check("w8_lat1", q1, RV1);
        d1 = 8'h02;
        tick();
        check("w8_lat2", q1, RV1);
        d1 = 8'h03;
        tick();
        check("w8_out01", q1, 8'h01);
        tick();
        check("w8_out02", q1, 8'h02);
        tick();
        check("w8_out03", q1, 8'h03);

        for (int k = 0; k < N_RAND; k++) begin
            dh[k] = 8'($urandom);
            rh[k] = (k == 0) || ($urandom_range(0, 99) < 5);
            d0 = dh[k][0:0];
            d1 = dh[k];
            rst0 = rh[k];
            rst1 = rh[k];
            tick();
            e = model(k, 1, 8'h00);
            check("rand_s1", {7'd0, q0}, {7'd0, e[0]});
            check("rand_s3", q1, model(k, 3, RV1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
